// File: rtl/monster_game_sequencer.sv
// Game sequencer for the 2-lane, 6-column monster picture shifter: paces the
// shift/ready pulses, picks new monsters, judges punches and keeps score/lives.
module monster_game_sequencer #(
  parameter logic [23:0] SHIFT_PERIOD = 24'd5_000_000,
  parameter logic [23:0] MIN_PERIOD   = 24'd1_000_000,
  parameter logic [23:0] SPEED_STEP   = 24'd500_000,
  parameter logic [3:0]  SPEEDUP_HITS = 4'd8,
  parameter logic [1:0]  START_LIVES  = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       punch_up_i,
  input  logic       punch_down_i,
  output logic [1:0] monster_num_o,
  output logic       shift_o,
  output logic       ready_o,
  output logic       gaming_o,
  output logic       gameover_o,
  output logic [7:0] score_o,
  output logic [1:0] lives_o
);

  typedef enum logic [1:0] {IDLE, READY, GAMING, OVER} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [23:0]     tick_q, tick_d;
  logic [23:0]     period_q, period_d;
  logic [23:0]     active_q, active_d;
  logic [5:0][1:0] track_q, track_d;
  logic            up_done_q, up_done_d;
  logic            dn_done_q, dn_done_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic [3:0]      hit_cnt_q, hit_cnt_d;
  logic [2:0]      rdy_cnt_q, rdy_cnt_d;

  logic terminal, need_up, need_dn, up_left, dn_left, hit, miss, enter_ready;

  // period_q is what the next window will use; active_q times the current window.
  assign terminal    = (state_q == GAMING) && (tick_q == active_q - 24'd1);
  assign need_up     = ((track_q[0] == 2'd1) || (track_q[0] == 2'd2)) && !up_done_q;
  assign need_dn     = ((track_q[0] == 2'd2) || (track_q[0] == 2'd3)) && !dn_done_q;
  assign up_left     = need_up && !punch_up_i;
  assign dn_left     = need_dn && !punch_down_i;
  assign hit         = (state_q == GAMING) && (need_up || need_dn) && !(up_left || dn_left);
  assign miss        = terminal && (up_left || dn_left);
  assign enter_ready = ((state_q == IDLE) || (state_q == OVER)) && start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = READY;
      READY:   if (rdy_cnt_q == 3'd5) state_d = GAMING;
      GAMING:  if (miss && (lives_q == 2'd1)) state_d = OVER;
      OVER:    if (start_i) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_o       = terminal;
    monster_num_o = terminal ? lfsr_q[1:0] : 2'd0;
    ready_o       = (state_q == READY);
    gaming_o      = (state_q == GAMING);
    gameover_o    = (state_q == OVER);
    score_o       = score_q;
    lives_o       = lives_q;
  end

  // A punch in the shift cycle still counts for the outgoing column-0 monster.
  always_comb begin
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rdy_cnt_d = (state_q == READY) ? rdy_cnt_q + 3'd1 : 3'd0;
    tick_d    = ((state_q == GAMING) && !terminal) ? tick_q + 24'd1 : 24'd0;
    period_d  = period_q;
    active_d  = active_q;
    track_d   = track_q;
    up_done_d = up_done_q;
    dn_done_d = dn_done_q;
    score_d   = score_q;
    lives_d   = lives_q;
    hit_cnt_d = hit_cnt_q;
    if (enter_ready) begin
      period_d  = SHIFT_PERIOD;
      active_d  = SHIFT_PERIOD;
      track_d   = '0;
      up_done_d = 1'b0;
      dn_done_d = 1'b0;
      score_d   = 8'd0;
      lives_d   = START_LIVES;
      hit_cnt_d = 4'd0;
    end else if (state_q == GAMING) begin
      up_done_d = up_done_q || punch_up_i;
      dn_done_d = dn_done_q || punch_down_i;
      if (hit) begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        if (hit_cnt_q == SPEEDUP_HITS - 4'd1) begin
          hit_cnt_d = 4'd0;
          period_d  = (period_q >= MIN_PERIOD + SPEED_STEP) ? period_q - SPEED_STEP : MIN_PERIOD;
        end else begin
          hit_cnt_d = hit_cnt_q + 4'd1;
        end
      end
      if (terminal) begin
        track_d   = {lfsr_q[1:0], track_q[5:1]};
        up_done_d = 1'b0;
        dn_done_d = 1'b0;
        active_d  = period_d;
        if (miss && (lives_q != 2'd0)) lives_d = lives_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= 8'hA5;
      tick_q    <= 24'd0;
      period_q  <= SHIFT_PERIOD;
      active_q  <= SHIFT_PERIOD;
      track_q   <= '0;
      up_done_q <= 1'b0;
      dn_done_q <= 1'b0;
      score_q   <= 8'd0;
      lives_q   <= START_LIVES;
      hit_cnt_q <= 4'd0;
      rdy_cnt_q <= 3'd0;
    end else begin
      lfsr_q    <= lfsr_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
      active_q  <= active_d;
      track_q   <= track_d;
      up_done_q <= up_done_d;
      dn_done_q <= dn_done_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hit_cnt_q <= hit_cnt_d;
      rdy_cnt_q <= rdy_cnt_d;
    end
  end

endmodule

// File: tb/tb_monster_game_sequencer.sv
// Scoreboard bench for monster_game_sequencer: a window-countdown game model
// predicts every cycle's outputs, which are queued and compared on the falling edge.
module tb_monster_game_sequencer;

  localparam int PER  = 10;
  localparam int MINP = 4;
  localparam int STEP = 2;
  localparam int S_IDLE = 0, S_READY = 1, S_GAMING = 2, S_OVER = 3;
  localparam int M_PERFECT = 0, M_LATE = 1, M_MISS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startIn = 1'b0, punchUp = 1'b0, punchDown = 1'b0;
  logic [1:0] monsterNum;
  logic       shiftOut, readyOut, gamingOut, gameoverOut;
  logic [7:0] scoreOut;
  logic [1:0] livesOut;

  monster_game_sequencer #(
    .SHIFT_PERIOD(24'd10), .MIN_PERIOD(24'd4), .SPEED_STEP(24'd2),
    .SPEEDUP_HITS(4'd2), .START_LIVES(2'd3)
  ) dut (
    .clk(clk), .rst(rst), .start_i(startIn), .punch_up_i(punchUp), .punch_down_i(punchDown),
    .monster_num_o(monsterNum), .shift_o(shiftOut), .ready_o(readyOut), .gaming_o(gamingOut),
    .gameover_o(gameoverOut), .score_o(scoreOut), .lives_o(livesOut)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int mState, mReadyCnt, mLeft, mPeriod, mPending, mScore, mLives, mHits;
  logic [7:0] mLfsr;
  logic [1:0] mT[6];
  bit mNeedUp, mNeedDn;
  logic [15:0] expQ[$];
  int cycleNo = 0, lastShiftCyc = 0, lastGap = 0, shiftCount = 0, readyCount = 0;
  logic [7:0] dutScore;
  logic [1:0] dutLives;
  logic dutOver, dutReady;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] dutVec();
    return {monsterNum, shiftOut, readyOut, gamingOut, gameoverOut, scoreOut, livesOut};
  endfunction

  function automatic logic [15:0] modelOut();
    logic sh;
    sh = (mState == S_GAMING) && (mLeft == 1);
    return {sh ? mLfsr[1:0] : 2'd0, sh, mState == S_READY, mState == S_GAMING,
            mState == S_OVER, mScore[7:0], mLives[1:0]};
  endfunction

  function automatic void clearGame();
    mReadyCnt = 0; mPeriod = PER; mPending = PER; mLeft = PER;
    mScore = 0; mLives = 3; mHits = 0; mNeedUp = 0; mNeedDn = 0;
    for (int i = 0; i < 6; i++) mT[i] = 2'd0;
  endfunction

  function automatic void modelReset();
    mState = S_IDLE; mLfsr = 8'hA5; clearGame();
  endfunction

  function automatic int expPeriod(input int hits);
    int p;
    p = PER - STEP * (hits / 2);
    return (p < MINP) ? MINP : p;
  endfunction

  // One rising edge of the game: punches resolve before the window-end miss check.
  function automatic void modelStep(input logic st, input logic pu, input logic pd);
    logic [7:0] nl;
    bit hadNeed;
    nl = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    case (mState)
      S_IDLE, S_OVER: if (st) begin mState = S_READY; clearGame(); end
      S_READY: if (mReadyCnt == 5) begin mState = S_GAMING; mLeft = mPeriod; end
               else mReadyCnt++;
      default: begin
        hadNeed = mNeedUp || mNeedDn;
        if (pu) mNeedUp = 0;
        if (pd) mNeedDn = 0;
        if (hadNeed && !mNeedUp && !mNeedDn) begin
          if (mScore < 255) mScore++;
          mHits++;
          if (mHits % 2 == 0) mPending = (mPending - STEP < MINP) ? MINP : mPending - STEP;
        end
        if (mLeft == 1) begin
          if (mNeedUp || mNeedDn) begin
            if (mLives == 1) mState = S_OVER;
            if (mLives > 0) mLives--;
          end
          for (int i = 0; i < 5; i++) mT[i] = mT[i+1];
          mT[5] = mLfsr[1:0];
          mNeedUp = (mT[0] == 2'd1) || (mT[0] == 2'd2);
          mNeedDn = (mT[0] == 2'd2) || (mT[0] == 2'd3);
          mPeriod = mPending;
          mLeft = mPeriod;
        end else begin
          mLeft--;
        end
      end
    endcase
    mLfsr = nl;
  endfunction

  task automatic applyStimulus(input logic st, input logic pu, input logic pd);
    logic [15:0] expv;
    startIn = st; punchUp = pu; punchDown = pd;
    expQ.push_back(modelOut());
    #1;
    expv = expQ.pop_front();
    checkOutput("cyc", dutVec(), expv);
    if (mState == S_GAMING && mLeft == 1) checkOutput("mnum", monsterNum, mLfsr[1:0]);
    cycleNo++;
    if (shiftOut === 1'b1) begin
      lastGap = cycleNo - lastShiftCyc; lastShiftCyc = cycleNo; shiftCount++;
    end
    if (readyOut === 1'b1) readyCount++;
    dutScore = scoreOut; dutLives = livesOut; dutOver = gameoverOut; dutReady = readyOut;
    modelStep(st, pu, pd);
    @(negedge clk);
  endtask

  task automatic playWindow(input int mode);
    int wpos;
    bit pu, pd, wasShift;
    for (int i = 0; i < 100; i++) begin
      if (mState != S_GAMING) return;
      wpos = mPeriod - mLeft + 1;
      wasShift = (mLeft == 1);
      pu = 0; pd = 0;
      if (mode == M_PERFECT) begin pu = mNeedUp; pd = mNeedDn; end
      if (mode == M_LATE && wasShift) begin pu = mNeedUp; pd = mNeedDn; end
      if (wpos < 1) pu = 0;
      applyStimulus(1'b0, pu, pd);
      if (wasShift) return;
    end
    checkOutput("wtimeout", 0, 1);
  endtask

  task automatic runToFirstShift(input string tag);
    int n;
    applyStimulus(1'b1, 1'b0, 1'b0);
    readyCount = 0;
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("readycnt", readyCount, 6);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
      if (lastShiftCyc == cycleNo) break;
    end
    checkOutput(tag, n, 10);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int snap, s0, l0, sAtStart;
    bit found, downOnly;
    modelReset();
    repeat (2) @(negedge clk);
    #1 checkOutput("rstvec", dutVec(), 16'h0003);
    @(negedge clk);
    rst = 1'b0;

    // Start, six ready cycles, then steady 10-cycle windows.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runToFirstShift("firstgap");
    repeat (3) begin
      playWindow(M_PERFECT);
      checkOutput("gap", lastGap, 10);
    end

    // Find a "both" monster and hit it in two separate punches.
    found = 0;
    for (int w = 0; w < 80 && !found; w++) begin
      if (mState == S_GAMING && mNeedUp && mNeedDn) found = 1;
      else playWindow(M_PERFECT);
    end
    if (found) begin
      s0 = mScore;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("splitnone", dutScore, s0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("splithit", dutScore, s0 + 1);
      playWindow(M_PERFECT);
    end else begin
      checkOutput("find2", 0, 1);
    end

    // Miss everything until the game ends, then restart.
    for (int w = 0; w < 100 && mState == S_GAMING; w++) playWindow(M_MISS);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("overlives", dutLives, 0);
    checkOutput("overflag", dutOver, 1);
    snap = shiftCount;
    repeat (15) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("overshift", shiftCount - snap, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("relives", dutLives, 3);
    checkOutput("rescore", dutScore, 0);
    checkOutput("reready", dutReady, 1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    // Punch on the shift cycle every time; watch the window shrink to the floor.
    for (int w = 0; w < 80 && mHits < 8; w++) begin
      sAtStart = mScore;
      downOnly = mNeedDn && !mNeedUp;
      l0 = mLives; s0 = mScore;
      playWindow(M_LATE);
      if (w > 0) checkOutput("period", lastGap, expPeriod(sAtStart));
      if (downOnly) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("latelife", dutLives, l0);
        checkOutput("latehit", dutScore, s0 + 1);
      end
    end
    playWindow(M_LATE);
    checkOutput("minper", lastGap, 4);
    checkOutput("p5lives", dutLives, 3);

    // Reset in the middle of a window.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1; startIn = 1'b0; punchUp = 1'b0; punchDown = 1'b0;
    #1 checkOutput("rstmid", dutVec(), 16'h0003);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    snap = shiftCount;
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idleshift", shiftCount - snap, 0);
    runToFirstShift("firstgap2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
